softmax_lane_packer: RTL and testbench

- Upstream feeder for the N-lane max-reduction stage in the softmax datapath.
- Accepts a serial stream of Q6.10 scores, one per cycle, over a valid/ready handshake.
- Packs them into N-lane words (lane 0 = first element) and pads short final words with the most-negative value so lane max results are unaffected.
- Drives a lane-valid vector plus flat data; a separate real-lane mask and last flag are carried for downstream exp/normalise stages.

---
 rtl/softmax_lane_packer_if.sv | 42 ++++
 rtl/softmax_lane_packer.sv | 181 ++++++++++++++++++
 tb/tb_softmax_lane_packer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/softmax_lane_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : softmax_lane_packer_if
// Brief    : Stream-in / lane-word-out bundle for softmax_lane_packer.
//            out_vec_len exists only when PACKER_VEC_LEN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface softmax_lane_packer_if #(
    parameter int N = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_data;
    logic                   in_last;
    logic                   out_ready;
    logic [N-1:0]           out_valid_vec;
    logic [N*16-1:0]        out_flat;
    logic [N-1:0]           out_mask;
    logic                   out_last;
`ifdef PACKER_VEC_LEN_EN
    logic [$clog2(N)+15:0]  out_vec_len;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid_vec, out_flat, out_mask, out_last, out_vec_len
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid_vec, out_flat, out_mask, out_last, out_vec_len
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid_vec, out_flat, out_mask, out_last
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid_vec, out_flat, out_mask, out_last
    );
`endif
endinterface
`default_nettype wire

// File: rtl/softmax_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : softmax_lane_packer
// Brief    : Packs a serial Q6.10 score stream into N-lane words, padding the
//            tail of short words. Optional vector length via PACKER_VEC_LEN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_lane_packer #(
    parameter int          N         = 8,
    parameter logic [15:0] PAD_VALUE = 16'h8000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    softmax_lane_packer_if.slave   bus
);

    localparam int c_PTR_W = $clog2(N);
    localparam int c_LEN_W = $clog2(N) + 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_PTR_W-1:0] r_ptr;
    logic [15:0]        r_fill [N];

    logic               r_out_valid;
    logic [N*16-1:0]    r_out_flat;
    logic [N-1:0]       r_out_mask;
    logic               r_out_last;

    logic [N*16-1:0]    r_hold_flat;
    logic [N-1:0]       r_hold_mask;
    logic               r_hold_last;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_complete;
    logic               w_slot_free;
    logic [N*16-1:0]    w_word_flat;
    logic [N-1:0]       w_word_mask;

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_complete  = w_accept & ((r_ptr == c_PTR_W'(N - 1)) | bus.in_last);
    assign w_slot_free = ~r_out_valid | bus.out_ready;

    // Completed word: earlier lanes from the fill buffer, current element at
    // r_ptr, padding above. Stale fill-buffer lanes are never exposed.
    always_comb begin
        w_word_flat = '0;
        w_word_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(r_ptr)) begin
                w_word_flat[i*16 +: 16] = r_fill[i];
                w_word_mask[i]          = 1'b1;
            end else if (i == int'(r_ptr)) begin
                w_word_flat[i*16 +: 16] = bus.in_data;
                w_word_mask[i]          = 1'b1;
            end else begin
                w_word_flat[i*16 +: 16] = PAD_VALUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_in_ready = 1'b1;
                if (w_complete && !w_slot_free) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_slot_free) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

`ifdef PACKER_VEC_LEN_EN
    logic [c_LEN_W-1:0] r_cnt;
    logic [c_LEN_W-1:0] r_out_len;
    logic [c_LEN_W-1:0] r_hold_len;
    logic [c_LEN_W-1:0] w_cnt_inc;
    logic [c_LEN_W-1:0] w_word_len;

    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + c_LEN_W'(1);
    assign w_word_len = bus.in_last ? w_cnt_inc : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_out_len  <= '0;
            r_hold_len <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= bus.in_last ? '0 : w_cnt_inc;
            end
            if (r_state == ST_FILL) begin
                if (w_complete && w_slot_free) begin
                    r_out_len <= w_word_len;
                end else if (w_complete) begin
                    r_hold_len <= w_word_len;
                end
            end else if (w_slot_free) begin
                r_out_len <= r_hold_len;
            end
        end
    end

    assign bus.out_vec_len = r_out_len;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_flat  <= '0;
            r_out_mask  <= '0;
            r_out_last  <= 1'b0;
            r_hold_flat <= '0;
            r_hold_mask <= '0;
            r_hold_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fill[r_ptr] <= bus.in_data;
                r_ptr         <= w_complete ? '0 : r_ptr + c_PTR_W'(1);
            end
            case (r_state)
                ST_FILL: begin
                    if (w_complete && w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_flat  <= w_word_flat;
                        r_out_mask  <= w_word_mask;
                        r_out_last  <= bus.in_last;
                    end else if (w_complete) begin
                        r_hold_flat <= w_word_flat;
                        r_hold_mask <= w_word_mask;
                        r_hold_last <= bus.in_last;
                    end else if (w_slot_free) begin
                        // A consumed word drops valid but keeps its data.
                        r_out_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_flat  <= r_hold_flat;
                        r_out_mask  <= r_hold_mask;
                        r_out_last  <= r_hold_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid_vec = {N{r_out_valid}};
    assign bus.out_flat      = r_out_flat;
    assign bus.out_mask      = r_out_mask;
    assign bus.out_last      = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_softmax_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_lane_packer
// Brief    : Directed self-checking bench for softmax_lane_packer (N = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_lane_packer;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    softmax_lane_packer_if #(.N(8)) bus ();

    softmax_lane_packer #(
        .N         (8),
        .PAD_VALUE (16'h8000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane_max(input logic [127:0] f, input logic [7:0] m);
        logic signed [15:0] mx;
        mx = 16'sh8000;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && ($signed(f[i*16 +: 16]) > mx)) mx = $signed(f[i*16 +: 16]);
        end
        return mx;
    endfunction

    initial begin
        logic [127:0] e;
        logic [127:0] w1;
        logic [127:0] w2;
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", bus.out_valid_vec, 8'h00);
        chk("rst_flat",  bus.out_flat, 128'h0);
        chk("rst_mask",  bus.out_mask, 8'h00);
        chk("rst_last",  bus.out_last, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);

        // Full-rate word 0400..0B00
        for (int i = 0; i < 8; i++) push(16'h0400 + 16'(i) * 16'h0100, i == 7);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 8; i++) e[i*16 +: 16] = 16'h0400 + 16'(i) * 16'h0100;
        chk("full_flat",  bus.out_flat, e);
        chk("full_valid", bus.out_valid_vec, 8'hFF);
        chk("full_mask",  bus.out_mask, 8'hFF);
        chk("full_last",  bus.out_last, 1'b1);
        idle();
        chk("full_consumed", bus.out_valid_vec, 8'h00);

        // Short vector
        push(16'hFC00, 1'b0);
        push(16'h0200, 1'b0);
        push(16'h0100, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        e = {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0100, 16'h0200, 16'hFC00};
        chk("short_flat",  bus.out_flat, e);
        chk("short_mask",  bus.out_mask, 8'h07);
        chk("short_last",  bus.out_last, 1'b1);
        chk("short_max",   lane_max(bus.out_flat, bus.out_mask), 16'h0200);
        idle();

        // Single element equal to the pad value
        push(16'h8000, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("single_flat",  bus.out_flat, {8{16'h8000}});
        chk("single_mask",  bus.out_mask, 8'h01);
        chk("single_last",  bus.out_last, 1'b1);
        chk("single_valid", bus.out_valid_vec, 8'hFF);
        idle();

        // in_last without in_valid is ignored
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        step();
        bus.in_last  = 1'b0;
        chk("ghost_last_valid", bus.out_valid_vec, 8'h00);

        // Backpressure across two words
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w1[i*16 +: 16] = 16'h1000 + 16'(i);
            w2[i*16 +: 16] = 16'h2000 + 16'(i);
        end
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 1'b0);
        chk("bp_w1_flat",  bus.out_flat, w1);
        chk("bp_w1_valid", bus.out_valid_vec, 8'hFF);
        for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i), 1'b0);
        chk("bp_w1_stable", bus.out_flat, w1);
        for (int i = 4; i < 8; i++) push(16'h2000 + 16'(i), i == 7);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("bp_hold_ready", bus.in_ready, 1'b0);
        chk("bp_hold_flat",  bus.out_flat, w1);
        chk("bp_hold_last",  bus.out_last, 1'b0);
        idle();
        chk("bp_hold2_ready", bus.in_ready, 1'b0);
        chk("bp_hold2_flat",  bus.out_flat, w1);
        bus.out_ready = 1'b1;
        idle();
        chk("bp_w2_flat",  bus.out_flat, w2);
        chk("bp_w2_valid", bus.out_valid_vec, 8'hFF);
        chk("bp_w2_last",  bus.out_last, 1'b1);
        chk("bp_w2_mask",  bus.out_mask, 8'hFF);
        chk("bp_ready",    bus.in_ready, 1'b1);
        idle();
        chk("bp_drained",  bus.out_valid_vec, 8'h00);

        // Reset mid-stream with a valid word and ptr = 3
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) push(16'h4000 + 16'(i), 1'b0);
        chk("pre_rst_valid", bus.out_valid_vec, 8'hFF);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", bus.out_valid_vec, 8'h00);
        chk("mid_rst_flat",  bus.out_flat, 128'h0);
        chk("mid_rst_mask",  bus.out_mask, 8'h00);
        chk("mid_rst_last",  bus.out_last, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
`ifdef PACKER_VEC_LEN_EN
        chk("mid_rst_len",   bus.out_vec_len, 19'd0);
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i), i == 7);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 8; i++) e[i*16 +: 16] = 16'h5000 + 16'(i);
        chk("post_rst_flat", bus.out_flat, e);
        chk("post_rst_mask", bus.out_mask, 8'hFF);
        chk("post_rst_last", bus.out_last, 1'b1);
        idle();

`ifdef PACKER_VEC_LEN_EN
        // 11-element vector: length appears only on the last word
        for (int i = 0; i < 8; i++) push(16'h0600 + 16'(i), 1'b0);
        chk("len_w1_len",  bus.out_vec_len, 19'd0);
        chk("len_w1_mask", bus.out_mask, 8'hFF);
        chk("len_w1_last", bus.out_last, 1'b0);
        for (int i = 8; i < 11; i++) push(16'h0600 + 16'(i), i == 10);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("len_w2_len",  bus.out_vec_len, 19'd11);
        chk("len_w2_mask", bus.out_mask, 8'h07);
        chk("len_w2_last", bus.out_last, 1'b1);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
